// File: rtl/clk_div_pkg.sv
// Shared types, defaults and width helpers for the programmable clock divider.
// The optional per-channel TICK output is enabled by defining CLK_DIV_TICK_EN.
package clk_div_pkg;

    localparam int CFG_WIDTH    = 16;
    localparam int DEFAULT_DIV  = 15;
    localparam int DEFAULT_HIGH = 7;

    typedef struct packed {
        logic [CFG_WIDTH-1:0] div;
        logic [CFG_WIDTH-1:0] high;
    } cfg_t;

    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // A single-channel build still needs a 1-bit channel select.
    function automatic int ch_idx_w(input int channels);
        return (channels > 1) ? clogb2(channels) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, shadowed div/high settings and registered output.
// Defining CLK_DIV_TICK_EN adds o_tick, a one-cycle pulse on each wrap to zero.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = CFG_WIDTH,
    parameter int RST_DIV  = DEFAULT_DIV,
    parameter int RST_HIGH = DEFAULT_HIGH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_cfg_div,
    input  logic [WIDTH-1:0] i_cfg_high,
    output logic             o_pend,
    output logic             o_out
`ifdef CLK_DIV_TICK_EN
    ,
    output logic             o_tick
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] high;
    } ch_cfg_t;

    localparam logic [WIDTH-1:0] RST_DIV_W  = WIDTH'(RST_DIV);
    localparam logic [WIDTH-1:0] RST_HIGH_W = WIDTH'(RST_HIGH);
    // Reset count sits on the last slot so the first enabled edge wraps and starts a full period.
    localparam logic [WIDTH-1:0] RST_CNT    = (RST_DIV >= 2) ? WIDTH'(RST_DIV - 1) :
                                              (RST_DIV == 1) ? WIDTH'(1) : '0;

    ch_cfg_t          r_act;
    ch_cfg_t          r_shd;
    ch_cfg_t          w_act_next;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_last;
    logic             r_pend;
    logic             r_out;
    logic             r_tick;
    logic             w_dis;
    logic             w_wrap;
    logic             w_apply;
    logic             w_out_next;

    // NOTE: every signal gets a value on every path of this block, so no latch is inferred.
    always_comb begin
        w_dis      = (r_act.div == '0);
        w_last     = (r_act.div < WIDTH'(2)) ? WIDTH'(1) : r_act.div - WIDTH'(1);
        w_wrap     = i_sync | (i_en & (w_dis | (r_cnt == w_last)));
        // A write landing on the boundary wins over applying the older shadow value.
        w_apply    = r_pend & (w_wrap | w_dis) & ~i_we;
        w_act_next = w_apply ? r_shd : r_act;

        if (w_wrap) begin
            w_cnt_next = '0;
        end else if (i_en & ~w_dis) begin
            w_cnt_next = r_cnt + WIDTH'(1);
        end else begin
            w_cnt_next = r_cnt;
        end

        w_out_next = (w_act_next.div != '0) && (w_cnt_next < w_act_next.high);
    end

    // NOTE: non-blocking assignments make every register sample the pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= RST_CNT;
            r_act  <= '{div: RST_DIV_W, high: RST_HIGH_W};
            r_shd  <= '0;
            r_pend <= 1'b0;
            r_out  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_act  <= w_act_next;
            r_cnt  <= w_cnt_next;
            r_tick <= w_wrap & (w_act_next.div != '0);
            if (i_sync | i_en) begin
                r_out <= w_out_next;
            end
            if (i_we) begin
                r_shd  <= '{div: i_cfg_div, high: i_cfg_high};
                r_pend <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pend = r_pend;
    assign o_out  = r_out;
`ifdef CLK_DIV_TICK_EN
    assign o_tick = r_tick;
`else
    logic w_tick_unused;
    assign w_tick_unused = r_tick;
`endif

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel runtime-programmable clock divider; decodes config writes to per-channel strobes.
// Defining CLK_DIV_TICK_EN adds the TICK output (one pulse per channel wrap).
module prog_clk_divider #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = clk_div_pkg::CFG_WIDTH,
    parameter int DEFAULT_DIV  = clk_div_pkg::DEFAULT_DIV,
    parameter int DEFAULT_HIGH = clk_div_pkg::DEFAULT_HIGH
) (
    input  logic                                      IN_CLK,
    input  logic                                      RST_N,
    input  logic                                      EN,
    input  logic                                      SYNC,
    input  logic                                      CFG_WE,
    input  logic [clk_div_pkg::ch_idx_w(CHANNELS)-1:0] CFG_CH,
    input  logic [WIDTH-1:0]                          CFG_DIV,
    input  logic [WIDTH-1:0]                          CFG_HIGH,
    output logic [CHANNELS-1:0]                       CFG_PEND,
    output logic [CHANNELS-1:0]                       OUT_CLK
`ifdef CLK_DIV_TICK_EN
    ,
    output logic [CHANNELS-1:0]                       TICK
`endif
);

    import clk_div_pkg::*;

    localparam int CH_W = ch_idx_w(CHANNELS);

    logic [CHANNELS-1:0] w_we;

    // Out-of-range channel numbers match no index and are dropped.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_we[i] = CFG_WE && (CFG_CH == CH_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clk_div_channel #(
            .WIDTH    (WIDTH),
            .RST_DIV  (DEFAULT_DIV),
            .RST_HIGH (DEFAULT_HIGH)
        ) u_ch (
            .i_clk      (IN_CLK),
            .i_rst_n    (RST_N),
            .i_en       (EN),
            .i_sync     (SYNC),
            .i_we       (w_we[g]),
            .i_cfg_div  (CFG_DIV),
            .i_cfg_high (CFG_HIGH),
            .o_pend     (CFG_PEND[g]),
            .o_out      (OUT_CLK[g])
`ifdef CLK_DIV_TICK_EN
            ,
            .o_tick     (TICK[g])
`endif
        );
    end

endmodule
